// File: rtl/line_stream_gearbox.sv
// Ping-pong line buffer: stores PIXEL_PER_CLK-pixel beats per line, replays them as OUT_PIXELS-pixel words.
// Define LINE_STREAM_GEARBOX_STATS_EN to add drop_count_o and last_len_o.
module line_stream_gearbox #(
    parameter int unsigned PIXEL_PER_CLK = 8,
    parameter int unsigned OUT_PIXELS    = 2,
    parameter int unsigned LINE_DEPTH    = 512
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        frame_sync_i,
    input  logic                        line_valid_i,
    input  logic [PIXEL_PER_CLK*16-1:0] data_i,
    input  logic                        data_valid_i,
    output logic [OUT_PIXELS*16-1:0]    out_data_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        out_sol_o,
    output logic                        out_eol_o,
    output logic                        line_drop_o,
    output logic                        line_trunc_o,
`ifdef LINE_STREAM_GEARBOX_STATS_EN
    output logic [15:0]                 drop_count_o,
    output logic [$clog2(LINE_DEPTH):0] last_len_o,
`endif
    output logic                        busy_o
);

    localparam int unsigned IN_W  = PIXEL_PER_CLK * 16;
    localparam int unsigned OUT_W = OUT_PIXELS * 16;
    localparam int unsigned RATIO = PIXEL_PER_CLK / OUT_PIXELS;
    localparam int unsigned AW    = $clog2(LINE_DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];

    logic [IN_W-1:0] mem_q [2*LINE_DEPTH];
    logic [LW-1:0]   len_q [2];

    logic          lv_q;
    logic          wr_active_q;
    logic          wr_bank_q;
    logic [LW-1:0] wr_ptr_q;
    logic          trunc_seen_q;
    logic          last_commit_q;

    logic          rd_bank_q;
    logic [LW-1:0] rd_addr_q;
    logic          ram_vld_q;
    logic          ram_first_q;
    logic          ram_last_q;
    logic [IN_W-1:0] ram_q;

    logic [IN_W-1:0] fifo_beat_q [2];
    logic [1:0]      fifo_first_q;
    logic [1:0]      fifo_last_q;
    logic            fifo_wp_q;
    logic            fifo_rp_q;
    logic [1:0]      fifo_cnt_q;
    logic [SW-1:0]   sub_q;

    // Line boundary and bank availability
    logic rise_c, fall_c, release_c, avail0_c, avail1_c;
    logic accept_c, drop_c, new_bank_c, commit_c;

    assign rise_c     = line_valid_i && !lv_q;
    assign fall_c     = !line_valid_i && lv_q;
    assign release_c  = out_valid_o && out_ready_i && out_eol_o;
    assign avail0_c   = (bank_q[0] == BANK_EMPTY) || (release_c && !rd_bank_q);
    assign avail1_c   = (bank_q[1] == BANK_EMPTY) || (release_c && rd_bank_q);
    assign accept_c   = rise_c && !frame_sync_i && (avail0_c || avail1_c);
    assign drop_c     = rise_c && !frame_sync_i && !avail0_c && !avail1_c;
    assign new_bank_c = !avail0_c;
    assign commit_c   = fall_c && wr_active_q && !frame_sync_i;

    // Write port: the beat arriving with the rising edge is the first beat of the line
    logic          wr_en_c, room_c, trunc_c, cur_bank_c;
    logic [LW-1:0] cur_ptr_c;

    assign cur_ptr_c  = accept_c ? '0 : wr_ptr_q;
    assign cur_bank_c = accept_c ? new_bank_c : wr_bank_q;
    assign wr_en_c    = line_valid_i && data_valid_i && !frame_sync_i && (accept_c || wr_active_q);
    assign room_c     = cur_ptr_c < LW'(LINE_DEPTH);
    assign trunc_c    = wr_en_c && !room_c && !trunc_seen_q;

    // Read arbiter and issue: at most two beats in flight or queued ahead of the output
    logic          draining_c, full0_c, full1_c, sel_c, sel_bank_c;
    logic          pop_c, load_c, last_sub_c, space_c, iss_c, iss_bank_c;
    logic [LW-1:0] iss_addr_c, iss_len_c;

    assign draining_c = (bank_q[0] == BANK_DRAINING) || (bank_q[1] == BANK_DRAINING);
    assign full0_c    = bank_q[0] == BANK_FULL;
    assign full1_c    = bank_q[1] == BANK_FULL;
    assign sel_c      = !draining_c && (full0_c || full1_c) && !frame_sync_i;
    assign sel_bank_c = (full0_c && full1_c) ? !last_commit_q : full1_c;

    assign iss_bank_c = sel_c ? sel_bank_c : rd_bank_q;
    assign iss_addr_c = sel_c ? '0 : rd_addr_q;
    assign iss_len_c  = len_q[iss_bank_c];
    assign space_c    = ({1'b0, fifo_cnt_q} + {2'b0, ram_vld_q}) <= ({2'b0, pop_c} + 3'd1);
    assign iss_c      = space_c && (sel_c || (bank_q[rd_bank_q] == BANK_DRAINING))
                        && (iss_addr_c < iss_len_c);

    logic [IN_W-1:0]  head_beat_c;
    logic [OUT_W-1:0] head_word_c;

    assign head_beat_c = fifo_beat_q[fifo_rp_q];
    assign head_word_c = head_beat_c[sub_q*OUT_W +: OUT_W];
    assign load_c      = (!out_valid_o || out_ready_i) && (fifo_cnt_q != 2'd0);
    assign last_sub_c  = sub_q == SW'(RATIO - 1);
    assign pop_c       = load_c && last_sub_c;

    // Bank FSM next state
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            case (bank_q[b])
                BANK_EMPTY: begin
                    if (accept_c && (new_bank_c == 1'(b))) bank_d[b] = BANK_FILLING;
                end
                BANK_FILLING: begin
                    if (frame_sync_i) bank_d[b] = BANK_EMPTY;
                    else if (commit_c && (wr_bank_q == 1'(b)))
                        bank_d[b] = (wr_ptr_q != '0) ? BANK_FULL : BANK_EMPTY;
                end
                BANK_FULL: begin
                    if (frame_sync_i) bank_d[b] = BANK_EMPTY;
                    else if (sel_c && (sel_bank_c == 1'(b))) bank_d[b] = BANK_DRAINING;
                end
                BANK_DRAINING: begin
                    if (release_c && (rd_bank_q == 1'(b)))
                        bank_d[b] = (accept_c && (new_bank_c == 1'(b))) ? BANK_FILLING : BANK_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            busy_o    <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            busy_o    <= (bank_d[0] != BANK_EMPTY) || (bank_d[1] != BANK_EMPTY);
        end
    end

    // Write side bookkeeping
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lv_q          <= 1'b0;
            wr_active_q   <= 1'b0;
            wr_bank_q     <= 1'b0;
            wr_ptr_q      <= '0;
            trunc_seen_q  <= 1'b0;
            last_commit_q <= 1'b0;
            len_q[0]      <= '0;
            len_q[1]      <= '0;
            line_drop_o   <= 1'b0;
            line_trunc_o  <= 1'b0;
        end else begin
            lv_q         <= line_valid_i;
            line_drop_o  <= drop_c;
            line_trunc_o <= trunc_c;
            if (accept_c) begin
                wr_active_q  <= 1'b1;
                wr_bank_q    <= new_bank_c;
                trunc_seen_q <= 1'b0;
            end else if (fall_c || frame_sync_i) begin
                wr_active_q <= 1'b0;
            end
            if (wr_en_c && room_c) wr_ptr_q <= cur_ptr_c + LW'(1);
            else if (accept_c)     wr_ptr_q <= '0;
            if (trunc_c) trunc_seen_q <= 1'b1;
            if (commit_c && (wr_ptr_q != '0)) begin
                len_q[wr_bank_q] <= wr_ptr_q;
                last_commit_q    <= wr_bank_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_c && room_c) mem_q[{cur_bank_c, cur_ptr_c[AW-1:0]}] <= data_i;
        if (iss_c) ram_q <= mem_q[{iss_bank_c, iss_addr_c[AW-1:0]}];
        if (ram_vld_q) fifo_beat_q[fifo_wp_q] <= ram_q;
    end

    // Read issue, skid queue and output word register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_bank_q    <= 1'b0;
            rd_addr_q    <= '0;
            ram_vld_q    <= 1'b0;
            ram_first_q  <= 1'b0;
            ram_last_q   <= 1'b0;
            fifo_first_q <= '0;
            fifo_last_q  <= '0;
            fifo_wp_q    <= 1'b0;
            fifo_rp_q    <= 1'b0;
            fifo_cnt_q   <= '0;
            sub_q        <= '0;
            out_valid_o  <= 1'b0;
            out_data_o   <= '0;
            out_sol_o    <= 1'b0;
            out_eol_o    <= 1'b0;
        end else begin
            if (sel_c) rd_bank_q <= sel_bank_c;
            if (iss_c)      rd_addr_q <= iss_addr_c + LW'(1);
            else if (sel_c) rd_addr_q <= '0;
            ram_vld_q   <= iss_c;
            ram_first_q <= iss_addr_c == '0;
            ram_last_q  <= iss_addr_c == (iss_len_c - LW'(1));
            if (ram_vld_q) begin
                fifo_first_q[fifo_wp_q] <= ram_first_q;
                fifo_last_q[fifo_wp_q]  <= ram_last_q;
                fifo_wp_q               <= !fifo_wp_q;
            end
            if (pop_c) fifo_rp_q <= !fifo_rp_q;
            fifo_cnt_q <= fifo_cnt_q + 2'(ram_vld_q) - 2'(pop_c);
            if (load_c) begin
                out_valid_o <= 1'b1;
                out_data_o  <= head_word_c;
                out_sol_o   <= fifo_first_q[fifo_rp_q] && (sub_q == '0);
                out_eol_o   <= fifo_last_q[fifo_rp_q] && last_sub_c;
                sub_q       <= last_sub_c ? '0 : sub_q + SW'(1);
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

`ifdef LINE_STREAM_GEARBOX_STATS_EN
    // Statistics survive frame_sync_i; only reset clears them
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_count_o <= '0;
            last_len_o   <= '0;
        end else begin
            if (drop_c && (drop_count_o != 16'hFFFF)) drop_count_o <= drop_count_o + 16'd1;
            if (commit_c && (wr_ptr_q != '0)) last_len_o <= wr_ptr_q;
        end
    end
`endif

endmodule
